// File: rtl/inv_clarke_pkg.sv
// Shared types and constants for the inverse-Clarke scheduler: state encoding,
// result record and the fixed-point sqrt(3) coefficient.
package inv_clarke_pkg;

    localparam int N_CH_DEF    = 4;
    localparam int D_WIDTH_DEF = 32;
    localparam int Q_BITS_DEF  = 10;
    localparam int CH_W_DEF    = $clog2(N_CH_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        OUT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [CH_W_DEF-1:0]           ch;
        logic signed [D_WIDTH_DEF-1:0] a;
        logic signed [D_WIDTH_DEF-1:0] b;
        logic signed [D_WIDTH_DEF-1:0] c;
    } result_t;

    // floor(sqrt(3) * 2^q) evaluated as an exact integer square root of 3 * 4^q
    function automatic logic [63:0] sqrt3_q(input int q_bits);
        logic [127:0] target_v;
        logic [63:0]  root_v;
        logic [63:0]  trial_v;
        target_v = 128'd3 << (2 * q_bits);
        root_v   = 64'd0;
        for (int i = 63; i >= 0; i--) begin
            trial_v = root_v | (64'd1 << i);
            if ((128'(trial_v) * 128'(trial_v)) <= target_v) begin
                root_v = trial_v;
            end else begin
                root_v = root_v;
            end
        end
        return root_v;
    endfunction

endpackage

// File: rtl/inv_clarke_sched_rr_arbiter.sv
// Round-robin arbiter: searches upward from the channel after last_grant and
// returns a one-hot grant plus its index; all-zero when disabled.
import inv_clarke_pkg::*;

module rr_arbiter #(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0]         req,
    input  logic [$clog2(N_CH)-1:0] last_grant,
    input  logic                    enable,
    output logic [N_CH-1:0]         grant,
    output logic [$clog2(N_CH)-1:0] grant_idx
);

    localparam int IW = $clog2(N_CH);

    logic [N_CH-1:0] grant_s;
    logic [IW-1:0]   idx_s;
    logic [IW-1:0]   cand_s;
    logic            found_s;

    // first requesting channel in rotating priority order
    always_comb begin
        grant_s = {N_CH{1'b0}};
        idx_s   = {IW{1'b0}};
        cand_s  = {IW{1'b0}};
        found_s = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            cand_s = IW'((int'(last_grant) + i) % N_CH);
            if (enable && !found_s && req[cand_s]) begin
                found_s         = 1'b1;
                grant_s[cand_s] = 1'b1;
                idx_s           = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign grant     = grant_s;
    assign grant_idx = idx_s;

endmodule

// File: rtl/inv_clarke_sched.sv
// Shares one inverse-Clarke stage among N_CH channels (grant, multiply, output).
// Define INV_CLARKE_SAT_EN to saturate beta*sqrt(3) instead of wrapping it.
import inv_clarke_pkg::*;

module inv_clarke_sched #(
    parameter int N_CH    = N_CH_DEF,
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int Q_BITS  = Q_BITS_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_CH-1:0]                 req_valid,
    output logic [N_CH-1:0]                 req_ready,
    input  logic [N_CH-1:0][D_WIDTH-1:0]    req_alpha,
    input  logic [N_CH-1:0][D_WIDTH-1:0]    req_beta,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [$clog2(N_CH)-1:0]         out_ch,
    output logic signed [D_WIDTH-1:0]       out_a,
    output logic signed [D_WIDTH-1:0]       out_b,
    output logic signed [D_WIDTH-1:0]       out_c,
    output logic                            busy
);

    localparam int CW = $clog2(N_CH);
    localparam int PW = 2 * D_WIDTH;
    localparam logic signed [PW-1:0] SQRT3_K = PW'(sqrt3_q(Q_BITS));

    state_t                      state_r;
    state_t                      state_nx_s;
    logic [CW-1:0]               last_grant_r;
    logic [CW-1:0]               grant_idx_s;
    logic [N_CH-1:0]             grant_s;
    logic                        accept_s;
    logic                        out_fire_s;
    logic signed [D_WIDTH-1:0]   alpha_r;
    logic signed [D_WIDTH-1:0]   beta_r;
    logic [CW-1:0]               ch_r;
    logic signed [PW-1:0]        prod_s;
`ifdef INV_CLARKE_SAT_EN
    logic signed [PW-1:0]        shifted_s;
`endif
    logic signed [D_WIDTH-1:0]   bs3_s;
    logic signed [D_WIDTH:0]     neg_alpha_s;
    logic signed [D_WIDTH:0]     sum_b_s;
    logic signed [D_WIDTH:0]     sum_c_s;
    logic                        out_valid_r;
    logic                        busy_r;
    logic [CW-1:0]               out_ch_r;
    logic signed [D_WIDTH-1:0]   out_a_r;
    logic signed [D_WIDTH-1:0]   out_b_r;
    logic signed [D_WIDTH-1:0]   out_c_r;

    rr_arbiter #(
        .N_CH(N_CH)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_r),
        .enable     (state_r == IDLE),
        .grant      (grant_s),
        .grant_idx  (grant_idx_s)
    );

    assign req_ready  = grant_s;
    assign accept_s   = |grant_s;
    assign out_fire_s = out_valid_r & out_ready;

    // next-state selection
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nx_s = MUL;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            MUL: state_nx_s = OUT;
            OUT: begin
                if (out_fire_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = OUT;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // state, round-robin pointer and operand capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= CW'(N_CH - 1);
            alpha_r      <= {D_WIDTH{1'b0}};
            beta_r       <= {D_WIDTH{1'b0}};
            ch_r         <= {CW{1'b0}};
        end else begin
            state_r <= state_nx_s;
            if (accept_s) begin
                alpha_r      <= req_alpha[grant_idx_s];
                beta_r       <= req_beta[grant_idx_s];
                ch_r         <= grant_idx_s;
                last_grant_r <= grant_idx_s;
            end
        end
    end

    // beta*sqrt(3) scaling and the two half-sums; sums carry one guard bit
    always_comb begin
        prod_s = PW'(beta_r) * SQRT3_K;
`ifdef INV_CLARKE_SAT_EN
        shifted_s = prod_s >>> Q_BITS;
        if ((shifted_s[PW-1:D_WIDTH-1] == {(PW-D_WIDTH+1){1'b0}}) ||
            (shifted_s[PW-1:D_WIDTH-1] == {(PW-D_WIDTH+1){1'b1}})) begin
            bs3_s = shifted_s[D_WIDTH-1:0];
        end else if (shifted_s[PW-1]) begin
            bs3_s = {1'b1, {(D_WIDTH-1){1'b0}}};
        end else begin
            bs3_s = {1'b0, {(D_WIDTH-1){1'b1}}};
        end
`else
        bs3_s = D_WIDTH'(prod_s >>> Q_BITS);
`endif
        neg_alpha_s = -((D_WIDTH+1)'(alpha_r));
        sum_b_s     = neg_alpha_s + (D_WIDTH+1)'(bs3_s);
        sum_c_s     = neg_alpha_s - (D_WIDTH+1)'(bs3_s);
    end

    // result registers load on the MUL->OUT edge and hold through backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            out_ch_r    <= {CW{1'b0}};
            out_a_r     <= {D_WIDTH{1'b0}};
            out_b_r     <= {D_WIDTH{1'b0}};
            out_c_r     <= {D_WIDTH{1'b0}};
        end else begin
            out_valid_r <= (state_nx_s == OUT);
            busy_r      <= (state_nx_s != IDLE);
            if (state_r == MUL) begin
                out_ch_r <= ch_r;
                out_a_r  <= alpha_r;
                out_b_r  <= D_WIDTH'(sum_b_s >>> 1);
                out_c_r  <= D_WIDTH'(sum_c_s >>> 1);
            end
        end
    end

    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_ch    = out_ch_r;
    assign out_a     = out_a_r;
    assign out_b     = out_b_r;
    assign out_c     = out_c_r;

endmodule
